// File: rtl/decumulate_pkg.sv
// Shared definitions for the decumulate block: FSM state encoding and
// default sizing constants.
package decumulate_pkg;

  localparam int N_DEFAULT        = 8;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BORROW = 2'd2
  } state_t;

endpackage

// File: rtl/decumulate_if.sv
// Key, switch and LED bundle between the board side (master) and the
// decumulate core (slave).
interface decumulate_if #(
  parameter int N = 8
);
  logic         load_n;
  logic         take_n;
  logic [N-1:0] data;
  logic [N-1:0] total;
  logic         empty;
  logic         borrow;

  modport master (
    output load_n, take_n, data,
    input  total, empty, borrow
  );

  modport slave (
    input  load_n, take_n, data,
    output total, empty, borrow
  );
endinterface

// File: rtl/decumulate_key_press.sv
// Raw active-low pushbutton to one-cycle press pulse: 2-flop synchroniser,
// stability counter, debounced level and falling-edge pulse.
module key_press
  import decumulate_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_count;
  logic          r_press;
  logic          w_sync;

  assign w_sync  = r_sync[1];
  assign o_press = r_press;

  // The DEBOUNCE-th consecutive mismatching cycle commits the new level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_count <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (w_sync == r_level) begin
        r_count <= '0;
      end else if (r_count == CW'(DEBOUNCE - 1)) begin
        r_count <= '0;
        r_level <= w_sync;
        r_press <= ~w_sync;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/decumulate.sv
// Countdown register: load from switches on one key, subtract switches on
// the other, clamping at zero with a sticky borrow flag.
module decumulate
  import decumulate_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input logic         i_clk,
  input logic         i_rst,
  decumulate_if.slave bus
);

  logic         w_load;
  logic         w_take;
  logic [N:0]   w_diff;
  state_t       r_state;
  state_t       w_nextState;
  logic [N-1:0] r_total;
  logic [N-1:0] w_nextTotal;
  logic         r_borrow;
  logic         w_nextBorrow;

  key_press #(.DEBOUNCE(DEBOUNCE)) u_load (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_key_n (bus.load_n),
    .o_press (w_load)
  );

  key_press #(.DEBOUNCE(DEBOUNCE)) u_take (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_key_n (bus.take_n),
    .o_press (w_take)
  );

  // Top bit of the widened difference is the borrow out
  assign w_diff = {1'b0, r_total} - {1'b0, bus.data};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_EMPTY;
      r_total  <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_total  <= w_nextTotal;
      r_borrow <= w_nextBorrow;
    end
  end

  // Load has priority; takes only act while something is held
  always_comb begin
    w_nextState  = r_state;
    w_nextTotal  = r_total;
    w_nextBorrow = r_borrow;
    if (w_load) begin
      w_nextTotal  = bus.data;
      w_nextBorrow = 1'b0;
      w_nextState  = (bus.data != '0) ? ST_HOLD : ST_EMPTY;
    end else if (w_take && r_state == ST_HOLD) begin
      if (w_diff[N]) begin
        w_nextTotal  = '0;
        w_nextBorrow = 1'b1;
        w_nextState  = ST_BORROW;
      end else if (w_diff[N-1:0] == '0) begin
        w_nextTotal = '0;
        w_nextState = ST_EMPTY;
      end else begin
        w_nextTotal = w_diff[N-1:0];
      end
    end
  end

  assign bus.total  = r_total;
  assign bus.empty  = (r_total == '0);
  assign bus.borrow = r_borrow;

endmodule

// File: doc/decumulate.md
# decumulate

Countdown counterpart to the board-level accumulator. A value is loaded from the switches with one pushbutton. Each press of a second pushbutton subtracts the current switch value from the stored total, clamping at zero and flagging a borrow. Pushbutton inputs are raw active-low DE-series keys, so the block contains synchronisation, debouncing and press detection. Outputs drive LEDR directly: Total on LEDR[7:0], Empty on LEDR[8], Borrow on LEDR[9].

## Interface
- N, 8, width of Data and Total
- DEBOUNCE, 1_000_000, consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz); must be ≥ 1
- Clock  in  1  system clock (CLOCK_50)
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clock
- Load_n  in  1  raw active-low pushbutton that loads Total from Data
- Take_n  in  1  raw active-low pushbutton that subtracts Data from Total
- Data  in  N  switch value, sampled on the cycle a press pulse is acted on
- Total  out  N  stored running total
- Empty  out  1  high when Total == 0
- Borrow  out  1  sticky flag: the last take exceeded Total

## Operation
- Each key path runs through the following chain:
  - 2-flop synchroniser (reset value 1, i.e. released).
  - Debounced level register (reset value 1).
  - Stability counter (reset value 0). The counter increments while the synchroniser output differs from the debounced level, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE, the debounced level takes the synchroniser value and the counter clears.
  - A one-cycle press pulse is generated on the debounced 1→0 transition. Releases produce no pulse.
- Three FSM states:
  - EMPTY: Total == 0, Borrow == 0. Reset state.
  - HOLD: Total > 0.
  - BORROW: Total == 0, Borrow == 1.
- Transitions on a load pulse (from any state):
  - Total ← Data and Borrow ← 0.
  - Next state is HOLD if Data ≠ 0, otherwise EMPTY.
- Transitions on a take pulse:
  - From HOLD with Data < Total: Total ← Total − Data; stay in HOLD.
  - From HOLD with Data == Total: Total ← 0; go to EMPTY.
  - From HOLD with Data > Total: Total ← 0, Borrow ← 1; go to BORROW.
  - From EMPTY or BORROW: ignored. No state change and Borrow is not set.
- Data == 0 on a take leaves Total unchanged.
- Simultaneous load and take pulses in the same cycle: load wins and the take is discarded.
- Arithmetic:
  - Subtraction is N+1 bits wide, and bit N is the borrow.
  - Total never wraps.
  - Empty is a combinational decode of Total == 0.
- Reset asserted mid-debounce or mid-press:
  - All synchronisers, counters, debounced levels and the FSM return to reset values on that edge.
  - No pulse is produced from a press that was in progress at reset.
  - A key still held low after reset deasserts must debounce afresh (DEBOUNCE cycles) before it is accepted.
- Reset values: Total = 0, Empty = 1, Borrow = 0, state = EMPTY.

## Timing
- Key falling edge to press pulse: 2 sync edges + DEBOUNCE edges.
- Total/Borrow register on the edge after the pulse cycle.
- Key-to-output latency is therefore DEBOUNCE + 3 Clock edges.
- Low glitches shorter than DEBOUNCE cycles (post-sync) produce no pulse.
- A release must be stable for DEBOUNCE cycles before the next press can be recognised.
- Holding a key down produces exactly one pulse. There is no auto-repeat.
- Data is sampled only in the pulse cycle. Changes to Data at any other time have no effect.
- Total, Empty and Borrow are glitch-free registered values. Empty may be registered or decoded from registered Total.

## Structure
- Shared package decumulate_pkg holds:
  - the FSM state encoding (EMPTY, HOLD, BORROW);
  - the DEBOUNCE default constant.
- Sub-module key_press contains the synchroniser, debounce counter, debounced level and press pulse. It is parameterised by DEBOUNCE and instantiated once per key.
- The counter width is derived from DEBOUNCE.
- The top-level DE wrapper connects:
  - Load_n → KEY[1] and Take_n → KEY[0];
  - Data → SW[7:0];
  - Reset → SW[9], used as an active-high switch;
  - Total, Empty, Borrow → LEDR[9:0] as mapped in the summary.

## Test plan
All scenarios use N=8 and DEBOUNCE=4, giving a key-to-output latency of 7 edges.
- Reset for 2 cycles with keys released → Total=0x00, Empty=1, Borrow=0, and these values are held with no key activity.
- Data=0x64, Load_n low for 10 cycles → Total=0x64 exactly 7 edges after the fall, Empty=0. Holding Load_n for 20 cycles still gives exactly one load.
- From Total=0x64: Data=0x14, two separate Take_n presses, each released ≥ 4 cycles → Total=0x50 then 0x3C.
- Data=0x3C take → Total=0x00, Empty=1, Borrow=0. A further take with Data=0x05 → no change.
- Load 0x10, then take with Data=0x11 → Total=0x00, Borrow=1, Empty=1. Another take → no change. Load 0x08 → Total=0x08, Borrow=0.
- Boundary cases:
  - A 3-cycle low glitch on Take_n → no change.
  - Load_n and Take_n fall on the same cycle with Data=0x22 → Total=0x22.
  - Reset asserted 2 cycles into a press → no update; after reset deasserts with the key still held, the update occurs DEBOUNCE+3 edges later.
